// File: rtl/qdr_rd_arbiter.sv
// qdr_rd_arbiter: shares one QDR-II read port between NUM_REQ replay engines.
// Round-robin command arbitration gated by calibration, memory backpressure and
// the outstanding-command cap, plus an in-order tag FIFO that steers returned
// read beats back to the requester that issued the command.
// Optional build macro: QDR_RD_ARB_STATS_EN (per-requester grant counters).
module qdr_rd_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int MEM_ADDR_WIDTH   = 19,
  parameter int MEM_DATA_WIDTH   = 36,
  parameter int MEM_BURST_LENGTH = 2,
  parameter int TAG_FIFO_DEPTH   = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                sw_rst,
  input  logic                                cal_done,
  input  logic [NUM_REQ-1:0]                  req_en,
  input  logic [NUM_REQ-1:0]                  req_r_n,
  input  logic [NUM_REQ*MEM_ADDR_WIDTH-1:0]   req_ad_rd,
  output logic [NUM_REQ-1:0]                  req_rd_full,
  output logic [NUM_REQ-1:0]                  req_qr_valid,
  output logic [2*MEM_DATA_WIDTH-1:0]         req_qr_data,
  output logic                                mem_r_n,
  output logic [MEM_ADDR_WIDTH-1:0]           mem_ad_rd,
  input  logic                                mem_rd_full,
  input  logic                                mem_qr_valid,
  input  logic [MEM_DATA_WIDTH-1:0]           mem_qrl,
  input  logic [MEM_DATA_WIDTH-1:0]           mem_qrh,
  output logic [$clog2(TAG_FIFO_DEPTH):0]     inflight,
  output logic                                rd_err,
  output logic [NUM_REQ*32-1:0]               grant_count
);

  localparam int PTR_W = $clog2(TAG_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int REQ_W = $clog2(NUM_REQ);
  localparam int BEATS = MEM_BURST_LENGTH / 2;

  // Registered state
  logic                        cal_done_reg;
  logic [REQ_W-1:0]            rr_ptr_reg;
  logic                        gap_reg;
  logic                        mem_r_n_reg;
  logic [MEM_ADDR_WIDTH-1:0]   mem_ad_rd_reg;
  logic [NUM_REQ-1:0]          req_qr_valid_reg;
  logic [2*MEM_DATA_WIDTH-1:0] req_qr_data_reg;
  logic                        rd_err_reg;
  logic [CNT_W-1:0]            inflight_reg;
  logic [PTR_W-1:0]            wr_ptr_reg;
  logic [PTR_W-1:0]            rd_ptr_reg;
  logic [1:0]                  beat_cnt_reg;
  logic [REQ_W-1:0]            tag_mem [TAG_FIFO_DEPTH];

  // Combinational decode
  logic [NUM_REQ-1:0]          cand;
  logic [MEM_ADDR_WIDTH-1:0]   req_addr [NUM_REQ];
  logic [REQ_W-1:0]            winner;
  logic                        cand_hit;
  logic                        grant_ok;
  logic                        grant;
  logic [REQ_W-1:0]            rr_ptr_next;
  logic                        fifo_empty;
  logic [REQ_W-1:0]            head_tag;
  logic                        beat_ok;
  logic                        pop;

  // Per-requester candidate bit and address slice
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign cand[gi]     = ~req_r_n[gi] & req_en[gi];
      assign req_addr[gi] = req_ad_rd[gi*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
    end
  endgenerate

  // Round-robin search: walk offsets from far to near so the nearest
  // candidate at or after the pointer wins.
  always_comb begin
    winner   = '0;
    cand_hit = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand[(int'(rr_ptr_reg) + k) % NUM_REQ]) begin
        cand_hit = 1'b1;
        winner   = REQ_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
      end
    end
  end

  // The cap compares the registered count, so a same-cycle pop never lets
  // occupancy exceed DEPTH-1.
  assign grant_ok = cal_done_reg & ~mem_rd_full & ~sw_rst & ~gap_reg &
                    (inflight_reg <= CNT_W'(TAG_FIFO_DEPTH - 2));
  assign grant    = cand_hit & grant_ok;

  assign req_rd_full = grant ? ~(NUM_REQ'(1) << winner) : '1;
  assign rr_ptr_next = (winner == REQ_W'(NUM_REQ - 1)) ? '0 : winner + REQ_W'(1);

  // Return path: tag FIFO head is read asynchronously (small LUT memory) so
  // the beat can be routed in the cycle after it arrives.
  assign fifo_empty = (inflight_reg == '0);
  assign head_tag   = tag_mem[rd_ptr_reg];
  assign beat_ok    = mem_qr_valid & ~fifo_empty;
  assign pop        = beat_ok & (beat_cnt_reg == 2'(BEATS - 1));

  // Tag storage: write the winner index on every grant (no reset needed)
  always_ff @(posedge clk) begin
    if (grant) tag_mem[wr_ptr_reg] <= winner;
  end

  // Arbitration, command issue, tag FIFO pointers and return routing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cal_done_reg     <= 1'b0;
      rr_ptr_reg       <= '0;
      gap_reg          <= 1'b0;
      mem_r_n_reg      <= 1'b1;
      mem_ad_rd_reg    <= '0;
      req_qr_valid_reg <= '0;
      req_qr_data_reg  <= '0;
      rd_err_reg       <= 1'b0;
      inflight_reg     <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      beat_cnt_reg     <= '0;
    end else if (sw_rst) begin
      cal_done_reg     <= 1'b0;
      rr_ptr_reg       <= '0;
      gap_reg          <= 1'b0;
      mem_r_n_reg      <= 1'b1;
      mem_ad_rd_reg    <= '0;
      req_qr_valid_reg <= '0;
      req_qr_data_reg  <= '0;
      rd_err_reg       <= 1'b0;
      inflight_reg     <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      beat_cnt_reg     <= '0;
    end else begin
      cal_done_reg <= cal_done;
      // BL4 commands occupy two address-bus cycles: force a gap after each grant
      gap_reg      <= (MEM_BURST_LENGTH == 4) ? grant : 1'b0;
      mem_r_n_reg  <= ~grant;
      if (grant) begin
        mem_ad_rd_reg <= req_addr[winner];
        rr_ptr_reg    <= rr_ptr_next;
        wr_ptr_reg    <= wr_ptr_reg + PTR_W'(1);
      end

      if (beat_ok) begin
        req_qr_valid_reg <= NUM_REQ'(1) << head_tag;
        req_qr_data_reg  <= {mem_qrh, mem_qrl};
        beat_cnt_reg     <= pop ? 2'd0 : beat_cnt_reg + 2'd1;
      end else begin
        req_qr_valid_reg <= '0;
      end

      if (pop) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);

      // Beat with nothing outstanding: drop it and flag the error
      if (mem_qr_valid && fifo_empty) rd_err_reg <= 1'b1;

      case ({grant, pop})
        2'b10:   inflight_reg <= inflight_reg + CNT_W'(1);
        2'b01:   inflight_reg <= inflight_reg - CNT_W'(1);
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  assign mem_r_n      = mem_r_n_reg;
  assign mem_ad_rd    = mem_ad_rd_reg;
  assign req_qr_valid = req_qr_valid_reg;
  assign req_qr_data  = req_qr_data_reg;
  assign rd_err       = rd_err_reg;
  assign inflight     = inflight_reg;

`ifdef QDR_RD_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      logic [31:0] grant_cnt_reg;
      // Count accepted commands for requester gi; wraps naturally at 2^32
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             grant_cnt_reg <= '0;
        else if (sw_rst)                        grant_cnt_reg <= '0;
        else if (grant && winner == REQ_W'(gi)) grant_cnt_reg <= grant_cnt_reg + 32'd1;
      end
      assign grant_count[gi*32 +: 32] = grant_cnt_reg;
    end
  endgenerate
`else
  assign grant_count = '0;
`endif

endmodule

// File: tb/tb_qdr_rd_arbiter.sv
// Directed bench for qdr_rd_arbiter: a BL2 instance (dut) and a BL4 instance (dut4).
// Expected return tags/data are queued when commands/beats are driven and
// popped when the routed beat appears.
module tb_qdr_rd_arbiter;
  localparam int AW = 19;
  localparam int DW = 36;

  logic           clk = 1'b0;
  logic           rst_n, sw_rst, cal_done, mem_rd_full, mem_qr_valid, mem_qr_valid4;
  logic [3:0]     req_en, req_r_n, req_r_n4;
  logic [4*AW-1:0] req_ad_rd;
  logic [DW-1:0]  mem_qrl, mem_qrh;

  logic [3:0]     req_rd_full, req_qr_valid, req_rd_full4, req_qr_valid4;
  logic [2*DW-1:0] req_qr_data, req_qr_data4;
  logic           mem_r_n, mem_r_n4, rd_err, rd_err4;
  logic [AW-1:0]  mem_ad_rd, mem_ad_rd4;
  logic [5:0]     inflight, inflight4;
  logic [127:0]   grant_count, grant_count4;

  int vectors = 0;
  int miscompares = 0;
  int tag_q[$];
  logic [2*DW-1:0] data_q[$];

  always #5 clk = ~clk;

  qdr_rd_arbiter #(.NUM_REQ(4), .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW),
                   .MEM_BURST_LENGTH(2), .TAG_FIFO_DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst), .cal_done(cal_done),
    .req_en(req_en), .req_r_n(req_r_n), .req_ad_rd(req_ad_rd),
    .req_rd_full(req_rd_full), .req_qr_valid(req_qr_valid), .req_qr_data(req_qr_data),
    .mem_r_n(mem_r_n), .mem_ad_rd(mem_ad_rd), .mem_rd_full(mem_rd_full),
    .mem_qr_valid(mem_qr_valid), .mem_qrl(mem_qrl), .mem_qrh(mem_qrh),
    .inflight(inflight), .rd_err(rd_err), .grant_count(grant_count));

  qdr_rd_arbiter #(.NUM_REQ(4), .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW),
                   .MEM_BURST_LENGTH(4), .TAG_FIFO_DEPTH(32)) dut4 (
    .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst), .cal_done(cal_done),
    .req_en(req_en), .req_r_n(req_r_n4), .req_ad_rd(req_ad_rd),
    .req_rd_full(req_rd_full4), .req_qr_valid(req_qr_valid4), .req_qr_data(req_qr_data4),
    .mem_r_n(mem_r_n4), .mem_ad_rd(mem_ad_rd4), .mem_rd_full(mem_rd_full),
    .mem_qr_valid(mem_qr_valid4), .mem_qrl(mem_qrl), .mem_qrh(mem_qrh),
    .inflight(inflight4), .rd_err(rd_err4), .grant_count(grant_count4));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] full_for(input int id);
    logic [3:0] f;
    f = ~(4'b0001 << id);
    return f;
  endfunction

  function automatic logic [3:0] onehot(input int id);
    logic [3:0] o;
    o = 4'b0001 << id;
    return o;
  endfunction

  // Single requester issues one command and is released once accepted
  task automatic issue(input int id, input logic [AW-1:0] addr);
    req_ad_rd[id*AW +: AW] = addr;
    req_r_n[id] = 1'b0;
    #1;
    check("issue_full", req_rd_full, full_for(id));
    tag_q.push_back(id);
    step();
    req_r_n[id] = 1'b1;
    check("issue_mem_r_n", mem_r_n, 1'b0);
    check("issue_addr", mem_ad_rd, addr);
    $display("issue req%0d addr %0h", id, addr);
  endtask

  // One return beat on the BL2 instance, checked against the scoreboard
  task automatic beat();
    logic [2*DW-1:0] d;
    int t;
    mem_qrh = DW'($urandom());
    mem_qrl = DW'($urandom());
    d = {mem_qrh, mem_qrl};
    data_q.push_back(d);
    mem_qr_valid = 1'b1;
    step();
    mem_qr_valid = 1'b0;
    t = tag_q.pop_front();
    check("ret_valid", req_qr_valid, onehot(t));
    check("ret_data", req_qr_data, data_q.pop_front());
    $display("beat -> req%0d data %0h", t, d);
  endtask

  initial begin
    int cnt, g;
    logic [3:0] e;
    logic [2*DW-1:0] d;

    rst_n = 1'b0; sw_rst = 1'b0; cal_done = 1'b0; mem_rd_full = 1'b0;
    mem_qr_valid = 1'b0; mem_qr_valid4 = 1'b0;
    req_en = 4'hF; req_r_n = 4'hF; req_r_n4 = 4'hF;
    mem_qrl = '0; mem_qrh = '0;
    for (int i = 0; i < 4; i++) req_ad_rd[i*AW +: AW] = AW'(19'h10 + i);

    // Reset state
    step(); step();
    check("rst_mem_r_n", mem_r_n, 1'b1);
    check("rst_mem_ad_rd", mem_ad_rd, '0);
    check("rst_qr_valid", req_qr_valid, '0);
    check("rst_qr_data", req_qr_data, '0);
    check("rst_rd_err", rd_err, 1'b0);
    check("rst_inflight", inflight, '0);
    rst_n = 1'b1;

    // Calibration gating: all requesting, no grants until cal_done_r
    req_r_n = 4'h0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("cal_full", req_rd_full, 4'hF);
      step();
      check("cal_mem_r_n", mem_r_n, 1'b1);
    end
    cal_done = 1'b1;
    #1;
    check("cal_full_sync", req_rd_full, 4'hF);
    step();

    // BL2 round robin: 8 back-to-back grants 0,1,2,3,0,1,2,3
    for (int k = 0; k < 8; k++) begin
      check("rr_full", req_rd_full, full_for(k % 4));
      tag_q.push_back(k % 4);
      step();
      if (k == 7) req_r_n = 4'hF;
      check("rr_mem_r_n", mem_r_n, 1'b0);
      check("rr_addr", mem_ad_rd, AW'(19'h10 + (k % 4)));
      $display("rr grant %0d -> req%0d", k, k % 4);
    end
    check("rr_inflight", inflight, 6'd8);
`ifdef QDR_RD_ARB_STATS_EN
    check("rr_grant_count", grant_count, {4{32'd2}});
`else
    check("rr_grant_count", grant_count, '0);
`endif
    step();
    check("rr_idle_mem_r_n", mem_r_n, 1'b1);

    // Drain the 8 outstanding commands in order
    for (int b = 0; b < 8; b++) beat();
    check("drain_inflight", inflight, '0);

    // Return routing: req1 @0x100 then req3 @0x200
    issue(1, 19'h100);
    issue(3, 19'h200);
    beat();
    beat();

    // Memory backpressure: 5 cycles with mem_rd_full=1
    req_r_n = 4'h0;
    mem_rd_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_full", req_rd_full, 4'hF);
      step();
      check("bp_mem_r_n", mem_r_n, 1'b1);
    end
    mem_rd_full = 1'b0;
    #1;

    // Occupancy cap: no returns, grants stop at 31 outstanding
    cnt = 0; g = 0;
    for (int c = 0; c < 36; c++) begin
      e = (cnt <= 30) ? full_for(g % 4) : 4'hF;
      check("cap_full", req_rd_full, e);
      if (cnt <= 30) begin
        tag_q.push_back(g % 4);
        cnt++;
        g++;
      end
      step();
    end
    req_r_n = 4'hF;
    check("cap_inflight", inflight, 6'd31);
    check("cap_mem_r_n", mem_r_n, 1'b1);
    $display("cap reached inflight %0d", inflight);
    for (int b = 0; b < 31; b++) beat();
    check("cap_drain_inflight", inflight, '0);

    // Error: beat with nothing outstanding
    issue(1, 19'h0ABC);
    beat();
    mem_qrl = 36'h5; mem_qrh = 36'h6;
    mem_qr_valid = 1'b1;
    step();
    mem_qr_valid = 1'b0;
    check("err_no_valid", req_qr_valid, '0);
    check("err_rd_err", rd_err, 1'b1);
    step();
    check("err_sticky", rd_err, 1'b1);
    $display("empty beat -> rd_err %0b", rd_err);

    // sw_rst clears error and pointer (which was at 2)
    sw_rst = 1'b1;
    req_r_n = 4'h0;
    #1;
    check("swrst_full", req_rd_full, 4'hF);
    step();
    sw_rst = 1'b0;
    #1;
    check("swrst_rd_err", rd_err, 1'b0);
    check("swrst_inflight", inflight, '0);
    check("swrst_mem_r_n", mem_r_n, 1'b1);
    check("swrst_cal_regate", req_rd_full, 4'hF);
    step();
    check("swrst_ptr0", req_rd_full, 4'b1110);
    tag_q.push_back(0);
    step();
    req_r_n = 4'hF;
    check("swrst_mem_r_n_grant", mem_r_n, 1'b0);
    check("swrst_addr", mem_ad_rd, AW'(19'h10));
    beat();

    // BL4: req0 and req2 active -> grant every other cycle
    req_ad_rd[0 +: AW] = 19'h4000;
    req_ad_rd[2*AW +: AW] = 19'h4200;
    req_r_n4 = 4'b1010;
    #1;
    for (int c = 0; c < 8; c++) begin
      if (c % 2 == 0) begin
        g = ((c / 2) % 2 == 0) ? 0 : 2;
        check("bl4_full", req_rd_full4, full_for(g));
        tag_q.push_back(g);
      end else begin
        check("bl4_gap_full", req_rd_full4, 4'hF);
      end
      step();
      if (c == 7) req_r_n4 = 4'hF;
      check("bl4_mem_r_n", mem_r_n4, (c % 2 == 0) ? 1'b0 : 1'b1);
      if (c % 2 == 0) check("bl4_addr", mem_ad_rd4, (g == 0) ? 19'h4000 : 19'h4200);
      $display("bl4 cycle %0d mem_r_n %0b", c, mem_r_n4);
    end
    check("bl4_inflight", inflight4, 6'd4);
    for (int b = 0; b < 8; b++) begin
      mem_qrh = DW'($urandom());
      mem_qrl = DW'($urandom());
      d = {mem_qrh, mem_qrl};
      mem_qr_valid4 = 1'b1;
      step();
      check("bl4_ret_valid", req_qr_valid4, onehot(tag_q[0]));
      check("bl4_ret_data", req_qr_data4, d);
      if (b == 0) check("bl4_no_pop_first", inflight4, 6'd4);
      if (b == 1) check("bl4_pop_second", inflight4, 6'd3);
      $display("bl4 beat %0d -> req%0d", b, tag_q[0]);
      if (b % 2 == 1) void'(tag_q.pop_front());
    end
    mem_qr_valid4 = 1'b0;
    check("bl4_drain_inflight", inflight4, '0);
    check("bl4_rd_err", rd_err4, 1'b0);

    // Asynchronous reset mid-burst
    req_r_n = 4'h0;
    step();
    step();
    check("arst_pre_mem_r_n", mem_r_n, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_mem_r_n", mem_r_n, 1'b1);
    check("arst_inflight", inflight, '0);
    check("arst_full", req_rd_full, 4'hF);
    $display("async reset -> mem_r_n %0b inflight %0d", mem_r_n, inflight);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/qdr_rd_arbiter.md
Name: qdr_rd_arbiter

Overview:
- Shares one QDR-II read port between NUM_REQ pcap replay engines (one per output port); each engine sees a private mem_r_n/mem_ad_rd/mem_qr_valid style interface.
- Round-robin command arbitration, memory backpressure and calibration gating, plus an in-order tag FIFO that routes returned read beats to the issuing requester.
- Sits between the per-port replay engines and the QDR controller read channel.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MEM_ADDR_WIDTH, 19, QDR address width.
- MEM_DATA_WIDTH, 36, width of each of qrl/qrh.
- MEM_BURST_LENGTH, 2, 2 or 4; beats returned per command = MEM_BURST_LENGTH/2.
- TAG_FIFO_DEPTH, 32, maximum outstanding commands (power of 2); must cover the QDR read latency.

Ports:
- clk  in  1  core clock; sole clock.
- rst_n  in  1  asynchronous active-low reset.
- sw_rst  in  1  synchronous software reset, active high.
- cal_done  in  1  QDR calibration complete; registered once internally before use.
- req_en  in  NUM_REQ  per-requester enable mask.
- req_r_n  in  NUM_REQ  active-low read request; held until accepted.
- req_ad_rd  in  NUM_REQ*MEM_ADDR_WIDTH  request address; slice i belongs to requester i.
- req_rd_full  out  NUM_REQ  per-requester backpressure; 0 = request accepted this cycle.
- req_qr_valid  out  NUM_REQ  one-hot return beat valid.
- req_qr_data  out  2*MEM_DATA_WIDTH  return beat {qrh,qrl}; broadcast to all requesters.
- mem_r_n  out  1  active-low read command to the QDR controller.
- mem_ad_rd  out  MEM_ADDR_WIDTH  read command address.
- mem_rd_full  in  1  QDR read command FIFO full.
- mem_qr_valid  in  1  QDR read beat valid.
- mem_qrl  in  MEM_DATA_WIDTH  read data, low half.
- mem_qrh  in  MEM_DATA_WIDTH  read data, high half.
- inflight  out  log2(TAG_FIFO_DEPTH)+1  outstanding command count.
- rd_err  out  1  sticky: a beat arrived with no outstanding tag.
- grant_count  out  NUM_REQ*32  per-requester accepted-command counters; see Optional Feature.

Behaviour:
- Reset (rst_n low, async) and sw_rst (sync) have the same effect:
  - mem_r_n=1, mem_ad_rd=0, req_qr_valid=0, req_qr_data=0, rd_err=0, inflight=0.
  - Tag FIFO emptied, beat counter=0, round-robin pointer=0, cal_done_r=0.
- Candidate set: requester i is a candidate when req_r_n[i]=0 and req_en[i]=1.
- Grant is allowed only when all of the following hold:
  - cal_done_r=1, mem_rd_full=0, sw_rst=0;
  - inflight <= TAG_FIFO_DEPTH-2;
  - no BL4 gap cycle is pending.
- Winner: the first candidate at or after the pointer, wrapping modulo NUM_REQ.
- On a grant:
  - req_rd_full[winner]=0 combinationally; all other bits are 1.
  - With no grant, every bit of req_rd_full is 1.
  - Pointer advances to winner+1, wrapping from NUM_REQ-1 to 0.
- Command latency: a request accepted in cycle N gives mem_r_n=0 and mem_ad_rd=req address in cycle N+1; otherwise mem_r_n=1 and mem_ad_rd holds its last value.
- BL4: after each grant, the following cycle is a forced no-grant gap, so mem_r_n is low at most every other cycle. BL2 allows back-to-back grants.
- Tag FIFO:
  - Push the winner index on every grant.
  - Each mem_qr_valid beat increments the beat counter.
  - Pop on the last beat of a command: beat counter = MEM_BURST_LENGTH/2-1, after which the counter returns to 0.
- Return latency: a beat in cycle M gives req_qr_valid[head tag]=1 and req_qr_data={mem_qrh,mem_qrl} in cycle M+1.
- Return backpressure: none. Requesters must absorb every beat (their FIFOs reserve space per command).
- Empty-FIFO beat: a beat arriving with the tag FIFO empty is dropped and sets rd_err=1; rd_err holds until reset or sw_rst.
- Simultaneous push and pop: inflight is unchanged; the occupancy compare uses the registered count, so the cap still holds.
- cal_done falling mid-operation blocks new grants only; outstanding beats still return and are routed.
- sw_rst with inflight!=0 is illegal (software polls inflight==0 first); any late beats set rd_err.

Optional Feature:
- Macro: QDR_RD_ARB_STATS_EN.
- Defined: grant_count slice i is a 32-bit counter that increments on each grant to requester i. It wraps at 2^32 and clears on reset or sw_rst.
- Not defined: grant_count is tied to 0 and no counter logic is built.

Test Plan:
- Reset and calibration gating: cal_done=0 with all four req_r_n=0 -> req_rd_full=4'b1111 and mem_r_n=1; raise cal_done -> first grant to req0 two cycles later.
- Round-robin fairness, BL2: all four requesting continuously for 8 grants -> grant order 0,1,2,3,0,1,2,3 and mem_r_n low 8 consecutive cycles; with QDR_RD_ARB_STATS_EN, each grant_count=2.
- Return routing: grants to req1 at address 0x100, then req3 at 0x200; the model returns beats D1, D3 -> req_qr_valid=4'b0010 with D1, then 4'b1000 with D3.
- Backpressure: mem_rd_full=1 for 5 cycles -> no grants and no mem_r_n pulses; inflight capped at 31 when the model withholds returns (DEPTH=32).
- BL4: MEM_BURST_LENGTH=4, two requesters active -> mem_r_n low every other cycle; two beats per command; tag popped after the second beat.
- Error and reset: mem_qr_valid with inflight=0 -> rd_err=1, no req_qr_valid. sw_rst -> rd_err=0, pointer=0. rst_n low asynchronously mid-burst -> mem_r_n=1 immediately.
